// File: rtl/rotary_input.sv
// Conditioning front-end for the LCD panel controls: synchronises, filters and debounces
// the quadrature encoder and push switch, and emits clean one-clock step/button events.
module rotary_input #(
    parameter int SAMPLE_DIV     = 256,
    parameter int ENC_STABLE     = 2,
    parameter int BTN_DEB        = 128,
    parameter int BTN_ACTIVE_LOW = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_enc,
    input  logic       i_d_sw,
    output logic       o_step_up,
    output logic       o_step_dn,
    output logic [7:0] o_enc_pos,
    output logic       o_btn_state,
    output logic       o_press,
    output logic       o_release,
    output logic       o_changed,
    output logic       o_enc_err
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int RUN_W = $clog2(ENC_STABLE + 1);
    localparam int DEB_W = $clog2(BTN_DEB);

    typedef enum logic [2:0] {
        S_IDLE, S_CW1, S_CW2, S_CW3, S_CCW1, S_CCW2, S_CCW3, S_ERR
    } state_t;

    logic [1:0]       r_enc_s1, r_enc_s2;
    logic             r_sw_s1, r_sw_s2;
    logic             w_sw;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic [1:0]       r_enc_f, r_enc_cand;
    logic [RUN_W-1:0] r_enc_run, w_run_inc;
    logic             w_enc_acc;
    state_t           r_state, w_state_next;
    logic             w_up, w_dn;
    logic             r_btn_state;
    logic [DEB_W-1:0] r_deb_cnt;
    logic             w_btn_diff, w_btn_flip;
    logic             r_step_up, r_step_dn, r_press, r_release, r_changed;
    logic [7:0]       r_enc_pos;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_enc_s1 <= '0;
            r_enc_s2 <= '0;
            r_sw_s1  <= 1'b0;
            r_sw_s2  <= 1'b0;
            r_div    <= '0;
        end else begin
            r_enc_s1 <= i_enc;
            r_enc_s2 <= r_enc_s1;
            r_sw_s1  <= i_d_sw;
            r_sw_s2  <= r_sw_s1;
            r_div    <= w_tick ? '0 : r_div + DIV_W'(1);
        end
    end

    assign w_sw   = (BTN_ACTIVE_LOW != 0) ? ~r_sw_s2 : r_sw_s2;
    assign w_tick = (r_div == DIV_W'(SAMPLE_DIV - 1));

    // A code is accepted once it has been seen on ENC_STABLE consecutive ticks.
    assign w_run_inc = (r_enc_s2 == r_enc_cand) ? r_enc_run + RUN_W'(1) : RUN_W'(1);
    assign w_enc_acc = w_tick && (r_enc_s2 != r_enc_f) && (w_run_inc >= RUN_W'(ENC_STABLE));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_enc_f    <= '0;
            r_enc_cand <= '0;
            r_enc_run  <= '0;
        end else if (w_tick) begin
            if (r_enc_s2 == r_enc_f) begin
                r_enc_run <= '0;
            end else if (w_enc_acc) begin
                r_enc_f   <= r_enc_s2;
                r_enc_run <= '0;
            end else begin
                r_enc_cand <= r_enc_s2;
                r_enc_run  <= w_run_inc;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // Each state rests on one code; the accepted code moves forward, one back, or to ERR.
    always_comb begin
        w_state_next = r_state;
        w_up         = 1'b0;
        w_dn         = 1'b0;
        if (w_enc_acc) begin
            case (r_state)
                S_IDLE: case (r_enc_s2)
                    2'b01:   w_state_next = S_CW1;
                    2'b10:   w_state_next = S_CCW1;
                    2'b11:   w_state_next = S_ERR;
                    default: ;
                endcase
                S_CW1: case (r_enc_s2)
                    2'b11:   w_state_next = S_CW2;
                    2'b00:   w_state_next = S_IDLE;
                    default: w_state_next = S_ERR;
                endcase
                S_CW2: case (r_enc_s2)
                    2'b10:   w_state_next = S_CW3;
                    2'b01:   w_state_next = S_CW1;
                    default: w_state_next = S_ERR;
                endcase
                S_CW3: case (r_enc_s2)
                    2'b00:   begin w_state_next = S_IDLE; w_up = 1'b1; end
                    2'b11:   w_state_next = S_CW2;
                    default: w_state_next = S_ERR;
                endcase
                S_CCW1: case (r_enc_s2)
                    2'b11:   w_state_next = S_CCW2;
                    2'b00:   w_state_next = S_IDLE;
                    default: w_state_next = S_ERR;
                endcase
                S_CCW2: case (r_enc_s2)
                    2'b01:   w_state_next = S_CCW3;
                    2'b10:   w_state_next = S_CCW1;
                    default: w_state_next = S_ERR;
                endcase
                S_CCW3: case (r_enc_s2)
                    2'b00:   begin w_state_next = S_IDLE; w_dn = 1'b1; end
                    2'b11:   w_state_next = S_CCW2;
                    default: w_state_next = S_ERR;
                endcase
                default: if (r_enc_s2 == 2'b00) w_state_next = S_IDLE;
            endcase
        end
    end

    assign w_btn_diff = (w_sw != r_btn_state);
    assign w_btn_flip = w_tick && w_btn_diff && (r_deb_cnt == DEB_W'(BTN_DEB - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_btn_state <= 1'b0;
            r_deb_cnt   <= '0;
        end else if (w_tick) begin
            if (!w_btn_diff) begin
                r_deb_cnt <= '0;
            end else if (w_btn_flip) begin
                r_btn_state <= ~r_btn_state;
                r_deb_cnt   <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end
    end

    // Event sources are tick-qualified, so every registered pulse lasts exactly one clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_step_up <= 1'b0;
            r_step_dn <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_changed <= 1'b0;
            r_enc_pos <= '0;
        end else begin
            r_step_up <= w_up;
            r_step_dn <= w_dn;
            r_press   <= w_btn_flip & ~r_btn_state;
            r_release <= w_btn_flip & r_btn_state;
            r_changed <= w_up | w_dn | w_btn_flip;
            if (w_up)      r_enc_pos <= r_enc_pos + 8'd1;
            else if (w_dn) r_enc_pos <= r_enc_pos - 8'd1;
        end
    end

    assign o_step_up   = r_step_up;
    assign o_step_dn   = r_step_dn;
    assign o_enc_pos   = r_enc_pos;
    assign o_btn_state = r_btn_state;
    assign o_press     = r_press;
    assign o_release   = r_release;
    assign o_changed   = r_changed;
    assign o_enc_err   = (r_state == S_ERR);

endmodule

// File: tb/tb_rotary_input.sv
// Directed bench for rotary_input: detents, wrap, partial turns, glitches, illegal jumps,
// switch bounce (both polarities) and reset in mid-rotation.
module tb_rotary_input;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] enc = 2'b00;
    logic       d_sw = 1'b0;
    logic       d_sw_n;
    assign d_sw_n = ~d_sw;

    logic       up0, dn0, btn0, prs0, rel0, chg0, err0;
    logic [7:0] pos0;
    logic       up1, dn1, btn1, prs1, rel1, chg1, err1;
    logic [7:0] pos1;

    rotary_input #(.SAMPLE_DIV(4), .ENC_STABLE(2), .BTN_DEB(4), .BTN_ACTIVE_LOW(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enc(enc), .i_d_sw(d_sw),
        .o_step_up(up0), .o_step_dn(dn0), .o_enc_pos(pos0), .o_btn_state(btn0),
        .o_press(prs0), .o_release(rel0), .o_changed(chg0), .o_enc_err(err0)
    );

    rotary_input #(.SAMPLE_DIV(4), .ENC_STABLE(2), .BTN_DEB(4), .BTN_ACTIVE_LOW(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enc(enc), .i_d_sw(d_sw_n),
        .o_step_up(up1), .o_step_dn(dn1), .o_enc_pos(pos1), .o_btn_state(btn1),
        .o_press(prs1), .o_release(rel1), .o_changed(chg1), .o_enc_err(err1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_up = 0, n_dn = 0, n_chg = 0, n_prs = 0, n_rel = 0, n_both = 0;
    int n_prs1 = 0, n_rel1 = 0;
    int s_up, s_dn, s_chg, s_prs, s_rel, s_prs1, s_rel1;

    // Count high cycles of each pulse, so a stretched pulse shows up as an extra count.
    always @(posedge clk) begin
        #1;
        n_up   <= n_up   + (up0  ? 1 : 0);
        n_dn   <= n_dn   + (dn0  ? 1 : 0);
        n_chg  <= n_chg  + (chg0 ? 1 : 0);
        n_prs  <= n_prs  + (prs0 ? 1 : 0);
        n_rel  <= n_rel  + (rel0 ? 1 : 0);
        n_both <= n_both + ((up0 && dn0) ? 1 : 0);
        n_prs1 <= n_prs1 + (prs1 ? 1 : 0);
        n_rel1 <= n_rel1 + (rel1 ? 1 : 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic move(input logic [1:0] c);
        enc = c;
        wclk(16);
    endtask

    task automatic turn_cw;
        move(2'b01); move(2'b11); move(2'b10); move(2'b00);
    endtask

    task automatic turn_ccw;
        move(2'b10); move(2'b11); move(2'b01); move(2'b00);
    endtask

    task automatic snap;
        s_up = n_up; s_dn = n_dn; s_chg = n_chg; s_prs = n_prs; s_rel = n_rel;
        s_prs1 = n_prs1; s_rel1 = n_rel1;
    endtask

    initial begin
        // Reset state
        wclk(3);
        chk("rst_up", up0, 0);
        chk("rst_pos", pos0, 0);
        chk("rst_btn", btn0, 0);
        chk("rst_err", err0, 0);
        chk("rst_chg", chg0, 0);
        chk("rst_btn_al", btn1, 0);
        @(negedge clk) rst_n = 1'b1;
        wclk(20);

        // 1: clockwise detent
        snap();
        turn_cw();
        chk("cw_up", n_up - s_up, 1);
        chk("cw_dn", n_dn - s_dn, 0);
        chk("cw_chg", n_chg - s_chg, 1);
        chk("cw_pos", pos0, 1);

        // 2: counter-clockwise detents with wrap both ways
        snap();
        turn_ccw();
        chk("ccw_dn", n_dn - s_dn, 1);
        chk("ccw_up", n_up - s_up, 0);
        chk("ccw_pos0", pos0, 0);
        turn_ccw();
        chk("ccw_wrap", pos0, 255);
        turn_cw();
        chk("cw_wrap", pos0, 0);
        chk("wrap_steps", n_up - s_up, 1);

        // 3: partial turn, then a full turn with a short glitch at 11
        snap();
        move(2'b01); move(2'b11); move(2'b01); move(2'b00);
        chk("part_up", n_up - s_up, 0);
        chk("part_dn", n_dn - s_dn, 0);
        chk("part_pos", pos0, 0);
        move(2'b01); move(2'b11);
        enc = 2'b00;
        wclk(3);
        move(2'b11);
        chk("glitch_err", err0, 0);
        move(2'b10); move(2'b00);
        chk("glitch_up", n_up - s_up, 1);
        chk("glitch_pos", pos0, 1);

        // 4: illegal jumps
        snap();
        move(2'b11);
        chk("jump_err", err0, 1);
        move(2'b00);
        chk("jump_clr", err0, 0);
        move(2'b01); move(2'b10);
        chk("jump_cw1_err", err0, 1);
        move(2'b00);
        chk("jump_cw1_clr", err0, 0);
        chk("jump_nopulse", (n_up - s_up) + (n_dn - s_dn), 0);
        turn_cw();
        chk("jump_then_up", n_up - s_up, 1);
        chk("jump_pos", pos0, 2);

        // 5: switch bounce, then settle pressed; both polarities
        snap();
        for (int i = 0; i < 10; i++) begin
            d_sw = ~d_sw;
            wclk(6);
        end
        d_sw = 1'b1;
        wclk(8);
        chk("bounce_early", btn0, 0);
        wclk(24);
        chk("press_btn", btn0, 1);
        chk("press_cnt", n_prs - s_prs, 1);
        chk("press_norel", n_rel - s_rel, 0);
        chk("press_chg", n_chg - s_chg, 1);
        chk("press_btn_al", btn1, 1);
        chk("press_cnt_al", n_prs1 - s_prs1, 1);
        snap();
        d_sw = 1'b0;
        wclk(32);
        chk("rel_btn", btn0, 0);
        chk("rel_cnt", n_rel - s_rel, 1);
        chk("rel_noprs", n_prs - s_prs, 0);
        chk("rel_btn_al", btn1, 0);
        chk("rel_cnt_al", n_rel1 - s_rel1, 1);
        chk("step_excl", n_both, 0);

        // 6: reset in CW3 with the button held
        d_sw = 1'b1;
        wclk(32);
        chk("pre_rst_btn", btn0, 1);
        snap();
        move(2'b01); move(2'b11); move(2'b10);
        chk("pre_rst_pos", pos0, 2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pos", pos0, 0);
        chk("async_btn", btn0, 0);
        chk("async_up", up0, 0);
        enc = 2'b00;
        d_sw = 1'b0;
        wclk(4);
        rst_n = 1'b1;
        wclk(30);
        chk("rst_abort_up", n_up - s_up, 0);
        chk("rst_abort_pos", pos0, 0);
        turn_cw();
        chk("post_rst_up", n_up - s_up, 1);
        chk("post_rst_pos", pos0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
